// File: rtl/ntt_stage_controller.sv
// Stage sequencer for the 512-point NTT/INTT: walks four stages of 64 issue cycles, emitting twiddle group k and stage p.
// All outputs registered; a stall sampled at an edge turns the following RUN cycle into a bubble or freezes the GAP count.
module ntt_stage_controller #(
  parameter int STAGE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] conf,
  input  logic       stall,
  output logic [4:0] k,
  output logic [1:0] p,
  output logic       valid,
  output logic       last,
  output logic       busy,
  output logic       done,
  output logic [3:0] conf_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  localparam logic [3:0] GAP_LAST = 4'(STAGE_GAP - 1);

  state_t     r_state;
  logic [5:0] r_cyc;
  logic [3:0] r_gap;
  logic [4:0] r_k;
  logic [1:0] r_p;
  logic       r_valid;
  logic       r_last;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_conf;

  logic [5:0] w_cyc_nxt;
  logic [1:0] w_p_nxt;
  logic       w_final;

  // Group size shrinks toward the low stages: k holds for 32, 8, 2, 2 issues.
  function automatic logic [4:0] f_k(input logic [1:0] stage, input logic [5:0] c);
    case (stage)
      2'd3:    f_k = 5'(c >> 5);
      2'd2:    f_k = 5'(c >> 3);
      default: f_k = 5'(c >> 1);
    endcase
  endfunction

  assign w_cyc_nxt = r_cyc + 6'd1;
  assign w_p_nxt   = r_conf[0] ? (r_p + 2'd1) : (r_p - 2'd1);
  assign w_final   = r_conf[0] ? (r_p == 2'd3) : (r_p == 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_gap   <= '0;
      r_k     <= '0;
      r_p     <= 2'd3;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_conf  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_last <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_conf  <= conf;
            r_cyc   <= '0;
            r_k     <= '0;
            r_p     <= conf[0] ? 2'd0 : 2'd3;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stall) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end else if (r_cyc == 6'd63) begin
            r_last <= 1'b0;
            if (w_final) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (STAGE_GAP == 0) begin
              r_p     <= w_p_nxt;
              r_cyc   <= '0;
              r_k     <= '0;
              r_valid <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_gap   <= '0;
              r_valid <= 1'b0;
            end
          end else begin
            r_cyc   <= w_cyc_nxt;
            r_k     <= f_k(r_p, w_cyc_nxt);
            r_valid <= 1'b1;
            r_last  <= w_final && (w_cyc_nxt == 6'd63);
          end
        end
        S_GAP: begin
          if (!stall) begin
            if (r_gap == GAP_LAST) begin
              r_state <= S_RUN;
              r_gap   <= '0;
              r_cyc   <= '0;
              r_k     <= '0;
              r_p     <= w_p_nxt;
              r_valid <= 1'b1;
            end else begin
              r_gap <= r_gap + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign k        = r_k;
  assign p        = r_p;
  assign valid    = r_valid;
  assign last     = r_last;
  assign busy     = r_busy;
  assign done     = r_done;
  assign conf_out = r_conf;

endmodule
